// File: rtl/gb_video_pkg.sv
// gb_video_pkg: shared types for the OBJ fetch path.
// OBJ_CGB_PRIORITY_EN adds a per-slot OAM index used for CGB overwrite priority.
package gb_video_pkg;
    localparam int OBJ_SLOTS = 8;
    localparam logic [3:0] IDX_NONE = 4'hF;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_OAM0  = 3'd1;
    localparam logic [2:0] ST_OAM1  = 3'd2;
    localparam logic [2:0] ST_LO    = 3'd3;
    localparam logic [2:0] ST_HI    = 3'd4;
    localparam logic [2:0] ST_MERGE = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        OAM0  = ST_OAM0,
        OAM1  = ST_OAM1,
        LO    = ST_LO,
        HI    = ST_HI,
        MERGE = ST_MERGE,
        DONE  = ST_DONE
    } fetch_state_e;
    typedef struct packed {
        logic [1:0] color;
        logic       pal;
        logic [2:0] cgb_pal;
        logic       bg_prio;
`ifdef OBJ_CGB_PRIORITY_EN
        logic [3:0] idx;
`endif
    } obj_slot_t;
`ifdef OBJ_CGB_PRIORITY_EN
    localparam obj_slot_t SLOT_EMPTY = '{color: 2'd0, pal: 1'b0, cgb_pal: 3'd0, bg_prio: 1'b0, idx: IDX_NONE};
`else
    localparam obj_slot_t SLOT_EMPTY = '0;
`endif
endpackage

// File: rtl/sprite_fetch_unit_if.sv
// sprite_fetch_unit_if: evaluator/VRAM/mixer signals of the sprite fetch unit.
interface sprite_fetch_unit_if;
    logic        ce;
    logic        lcd_on;
    logic        isGBC;
    logic        sprite_fetch;
    logic [10:0] sprite_addr;
    logic [7:0]  sprite_attr;
    logic [3:0]  sprite_index;
    logic        sprite_fetch_done;
    logic        vram_rd;
    logic [12:0] vram_addr;
    logic        vram_bank;
    logic [7:0]  vram_data;
    logic        pix_shift;
    logic [1:0]  obj_color;
    logic        obj_pal;
    logic [2:0]  obj_cgb_pal;
    logic        obj_bg_prio;
    modport master (
        output ce, lcd_on, isGBC, sprite_fetch, sprite_addr, sprite_attr, sprite_index, vram_data, pix_shift,
        input  sprite_fetch_done, vram_rd, vram_addr, vram_bank, obj_color, obj_pal, obj_cgb_pal, obj_bg_prio
    );
    modport slave (
        input  ce, lcd_on, isGBC, sprite_fetch, sprite_addr, sprite_attr, sprite_index, vram_data, pix_shift,
        output sprite_fetch_done, vram_rd, vram_addr, vram_bank, obj_color, obj_pal, obj_cgb_pal, obj_bg_prio
    );
endinterface

// File: rtl/obj_pixel_shifter.sv
// obj_pixel_shifter: 8-slot OBJ pixel shifter with transparent-fill shift and priority merge.
// OBJ_CGB_PRIORITY_EN adds the OAM-index overwrite rule in CGB mode.
module obj_pixel_shifter
    import gb_video_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       clr,
    input  logic       shift,
    input  logic       merge,
    input  logic [7:0] lo,
    input  logic [7:0] hi,
    input  logic [7:0] attr,
`ifdef OBJ_CGB_PRIORITY_EN
    input  logic       cgb,
    input  logic [3:0] idx,
`endif
    output obj_slot_t  head
);
    obj_slot_t slot_q [OBJ_SLOTS];
    obj_slot_t slot_d [OBJ_SLOTS];
    obj_slot_t shifted [OBJ_SLOTS];
    obj_slot_t fresh [OBJ_SLOTS];
    logic [1:0] px [OBJ_SLOTS];
    logic [OBJ_SLOTS-1:0] win;
    logic unused_attr;
    assign unused_attr = ^{attr[6], attr[3]};
    // Shift happens before merge so a same-cycle merge lands in post-shift slots.
    always_comb begin
        for (int n = 0; n < OBJ_SLOTS - 1; n++)
            shifted[n] = shift ? slot_q[n+1] : slot_q[n];
        shifted[OBJ_SLOTS-1] = shift ? SLOT_EMPTY : slot_q[OBJ_SLOTS-1];
        for (int n = 0; n < OBJ_SLOTS; n++) begin
            px[n] = attr[5] ? {hi[n], lo[n]} : {hi[7-n], lo[7-n]};
            fresh[n] = SLOT_EMPTY;
            fresh[n].color = px[n];
            fresh[n].pal = attr[4];
            fresh[n].cgb_pal = attr[2:0];
            fresh[n].bg_prio = attr[7];
`ifdef OBJ_CGB_PRIORITY_EN
            fresh[n].idx = idx;
            win[n] = cgb && (idx < shifted[n].idx);
`else
            win[n] = 1'b0;
`endif
            slot_d[n] = (merge && px[n] != 2'd0 && (shifted[n].color == 2'd0 || win[n])) ? fresh[n] : shifted[n];
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            for (int n = 0; n < OBJ_SLOTS; n++)
                slot_q[n] <= SLOT_EMPTY;
        end else if (ce) begin
            slot_q <= slot_d;
        end
    end
    assign head = slot_q[0];
endmodule

// File: rtl/sprite_fetch_unit.sv
// sprite_fetch_unit: responder FSM for OBJ fetches; reads both tile-row planes and merges them into the OBJ shifter.
// OBJ_CGB_PRIORITY_EN enables CGB OAM-index priority in the shifter.
module sprite_fetch_unit
    import gb_video_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    sprite_fetch_unit_if.slave  bus
);
    fetch_state_e state_q, state_d;
    logic        done_q, done_d;
    logic [7:0]  lo_q, lo_d;
    logic [12:0] addr_q, addr_d;
    logic        sf, rd, merge;
    obj_slot_t   head;
    assign sf = bus.sprite_fetch;
    assign rd = state_q == LO || state_q == HI;
    assign merge = state_q == MERGE && sf;
    // Dropping the request at any point before the merge abandons the fetch.
    always_comb begin
        state_d = state_q;
        done_d = done_q;
        lo_d = lo_q;
        case (state_q)
            IDLE:    state_d = sf ? OAM0 : IDLE;
            OAM0:    state_d = sf ? OAM1 : IDLE;
            OAM1:    state_d = sf ? LO : IDLE;
            LO:      state_d = sf ? HI : IDLE;
            HI: begin
                lo_d = bus.vram_data;
                state_d = sf ? MERGE : IDLE;
            end
            MERGE, DONE: begin
                state_d = sf ? DONE : IDLE;
                done_d = sf;
            end
            default: state_d = IDLE;
        endcase
    end
    assign addr_d = state_q == LO ? {1'b0, bus.sprite_addr, 1'b0} :
                    state_q == HI ? {1'b0, bus.sprite_addr, 1'b1} : addr_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done_q <= 1'b0;
            lo_q <= 8'd0;
            addr_q <= 13'd0;
        end else if (!bus.lcd_on) begin
            state_q <= IDLE;
            done_q <= 1'b0;
        end else if (bus.ce) begin
            state_q <= state_d;
            done_q <= done_d;
            lo_q <= lo_d;
            addr_q <= addr_d;
        end
    end
    obj_pixel_shifter u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (bus.ce),
        .clr     (!bus.lcd_on),
        .shift   (bus.pix_shift),
        .merge   (merge),
        .lo      (lo_q),
        .hi      (bus.vram_data),
        .attr    (bus.sprite_attr),
`ifdef OBJ_CGB_PRIORITY_EN
        .cgb     (bus.isGBC),
        .idx     (bus.sprite_index),
`endif
        .head    (head)
    );
`ifndef OBJ_CGB_PRIORITY_EN
    logic unused_idx;
    assign unused_idx = ^bus.sprite_index;
`endif
    assign bus.sprite_fetch_done = done_q;
    assign bus.vram_rd = rd && bus.lcd_on;
    assign bus.vram_addr = addr_d;
    assign bus.vram_bank = rd && bus.isGBC && bus.sprite_attr[3];
    assign bus.obj_color = head.color;
    assign bus.obj_pal = head.pal;
    assign bus.obj_cgb_pal = head.cgb_pal;
    assign bus.obj_bg_prio = head.bg_prio;
endmodule
